dco_freq_lock: RTL and testbench

//   Frequency-acquisition controller: the driving end of the DCO tuning interface.

---
 rtl/adpll_pkg.sv | 23 ++
 rtl/dco_edge_counter.sv | 80 ++++++++
 rtl/dco_freq_lock.sv | 188 ++++++++++++++++++
 tb/tb_dco_freq_lock.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared types and default widths for the ADPLL frequency-acquisition slice.
//   seq_state_t : sequencer states of dco_freq_lock
//   phase_t     : search phase (coarse SAR, fine SAR, +/-1 tracking)
package adpll_pkg;

  localparam int unsigned CTW_W_DEF = 8;
  localparam int unsigned FTW_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DECIDE  = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    COARSE = 2'd0,
    FINE   = 2'd1,
    TRACK  = 2'd2
  } phase_t;

endpackage

// File: rtl/dco_edge_counter.sv
// Counts rising edges of the asynchronous DCO output over a fixed window.
// Ports:
//   clk, rst      : reference clock, synchronous active-high reset
//   start_window  : strobe, begins a new WIN_CYC-cycle window (count cleared)
//   abort         : stops a running window without reporting it
//   dco_clk_in    : DCO output, asynchronous to clk
//   meas_cnt      : count of the last completed window (saturating)
//   meas_valid    : one-cycle pulse when meas_cnt updates
module dco_edge_counter
  import adpll_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned WIN_CYC = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_window,
  input  logic             abort,
  input  logic             dco_clk_in,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             meas_valid
);

  localparam int unsigned TMR_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;

  logic             r_s1, r_s2, r_s3;
  logic             r_run;
  logic [TMR_W-1:0] r_tmr;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_meas;
  logic             r_valid;

  logic             w_rise;
  logic [CNT_W-1:0] w_cnt_next;

  always_comb begin
    w_rise     = r_s2 & ~r_s3;
    w_cnt_next = r_cnt;
    if (w_rise && (r_cnt != '1)) w_cnt_next = r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_run   <= 1'b0;
      r_tmr   <= '0;
      r_cnt   <= '0;
      r_meas  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_s1    <= dco_clk_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;
      if (abort) begin
        r_run <= 1'b0;
      end else if (start_window) begin
        r_run <= 1'b1;
        r_tmr <= '0;
        r_cnt <= '0;
      end else if (r_run) begin
        r_cnt <= w_cnt_next;
        // an edge seen on the last window cycle still belongs to this window
        if (r_tmr == TMR_W'(WIN_CYC - 1)) begin
          r_run   <= 1'b0;
          r_meas  <= w_cnt_next;
          r_valid <= 1'b1;
        end else begin
          r_tmr <= r_tmr + 1'b1;
        end
      end
    end
  end

  assign meas_cnt   = r_meas;
  assign meas_valid = r_valid;

endmodule

// File: rtl/dco_freq_lock.sv
// Frequency-acquisition controller driving the DCO tuning words.
// Coarse SAR on CTW, fine SAR on FTW, then +/-1 FTW tracking with lock detect.
// Ports:
//   clk, rst     : reference clock (> 2x f_dco), synchronous active-high reset
//   start        : pulse, (re)starts acquisition from any state
//   target_cnt   : wanted DCO rising edges per window
//   dco_clk_in   : DCO output, asynchronous
//   CTW, FTW     : coarse / fine tuning words (larger = faster)
//   enable       : DCO enable, set by start, cleared only by rst
//   busy         : acquisition/tracking active
//   locked       : frequency lock indicator
//   meas_cnt     : last completed window count
//   meas_valid   : one-cycle pulse when meas_cnt updates
module dco_freq_lock
  import adpll_pkg::*;
#(
  parameter int unsigned CTW_W        = CTW_W_DEF,
  parameter int unsigned FTW_W        = FTW_W_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned WIN_CYC      = 256,
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned LOCK_TOL     = 1,
  parameter int unsigned LOCK_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] target_cnt,
  input  logic             dco_clk_in,
  output logic [CTW_W-1:0] CTW,
  output logic [FTW_W-1:0] FTW,
  output logic             enable,
  output logic             busy,
  output logic             locked,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             meas_valid
);

  localparam int unsigned WMAX   = (CTW_W > FTW_W) ? CTW_W : FTW_W;
  localparam int unsigned BIDX_W = (WMAX > 1) ? $clog2(WMAX) : 1;
  localparam int unsigned SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned RUN_W  = $clog2(LOCK_WINDOWS + 1);

  localparam logic [CTW_W-1:0]      CTW_MID = {1'b1, {(CTW_W-1){1'b0}}};
  localparam logic [FTW_W-1:0]      FTW_MID = {1'b1, {(FTW_W-1){1'b0}}};
  localparam logic signed [CNT_W:0] TOL_P   = (CNT_W+1)'(LOCK_TOL);
  localparam logic signed [CNT_W:0] TOL_N   = -TOL_P;

  seq_state_t        r_state;
  phase_t            r_phase;
  logic [BIDX_W-1:0] r_bidx;
  logic [CTW_W-1:0]  r_ctw;
  logic [FTW_W-1:0]  r_ftw;
  logic              r_en;
  logic              r_busy;
  logic              r_locked;
  logic [SET_W-1:0]  r_settle;
  logic [RUN_W-1:0]  r_run;

  logic [CNT_W-1:0]  w_meas_cnt;
  logic              w_meas_valid;
  logic signed [CNT_W:0] w_err;
  logic              w_decide;
  logic              w_gt;
  logic              w_hi;
  logic              w_lo;
  logic              w_rail;
  logic              w_restart;
  logic              w_start_win;
  logic [RUN_W-1:0]  w_run_next;
  logic [BIDX_W-1:0] w_bidx_m1;

  always_comb begin
    w_decide    = (r_state == DECIDE);
    w_err       = $signed({1'b0, w_meas_cnt}) - $signed({1'b0, target_cnt});
    w_gt        = (w_meas_cnt > target_cnt);
    w_hi        = (w_err > TOL_P);
    w_lo        = (w_err < TOL_N);
    w_rail      = w_decide && (r_phase == TRACK) &&
                  ((w_hi && (r_ftw == '0)) || (w_lo && (r_ftw == '1)));
    // a TRACK step beyond either rail restarts acquisition exactly like start
    w_restart   = start || w_rail;
    w_start_win = !w_restart &&
                  (((r_state == SETTLE) && (r_settle == SET_W'(SETTLE_CYC - 1))) ||
                   (w_decide && (r_phase == TRACK) && !w_hi && !w_lo));
    w_run_next  = (r_run == '1) ? r_run : r_run + 1'b1;
    w_bidx_m1   = r_bidx - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_phase  <= COARSE;
      r_bidx   <= BIDX_W'(CTW_W - 1);
      r_ctw    <= CTW_MID;
      r_ftw    <= FTW_MID;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_locked <= 1'b0;
      r_settle <= '0;
      r_run    <= '0;
    end else if (w_restart) begin
      r_state  <= SETTLE;
      r_phase  <= COARSE;
      r_bidx   <= BIDX_W'(CTW_W - 1);
      r_ctw    <= CTW_MID;
      r_ftw    <= '0;
      r_en     <= 1'b1;
      r_busy   <= 1'b1;
      r_locked <= 1'b0;
      r_settle <= '0;
      r_run    <= '0;
    end else begin
      case (r_state)
        SETTLE: begin
          if (w_start_win) r_state <= MEASURE;
          else             r_settle <= r_settle + 1'b1;
        end
        MEASURE: begin
          if (w_meas_valid) r_state <= DECIDE;
        end
        DECIDE: begin
          r_settle <= '0;
          case (r_phase)
            COARSE: begin
              r_state <= SETTLE;
              if (w_gt) r_ctw[r_bidx] <= 1'b0;
              if (r_bidx != '0) begin
                r_bidx           <= w_bidx_m1;
                r_ctw[w_bidx_m1] <= 1'b1;
              end else begin
                r_phase        <= FINE;
                r_bidx         <= BIDX_W'(FTW_W - 1);
                r_ftw[FTW_W-1] <= 1'b1;
              end
            end
            FINE: begin
              r_state <= SETTLE;
              if (w_gt) r_ftw[r_bidx] <= 1'b0;
              if (r_bidx != '0) begin
                r_bidx           <= w_bidx_m1;
                r_ftw[w_bidx_m1] <= 1'b1;
              end else begin
                r_phase <= TRACK;
              end
            end
            default: begin
              // rails are already diverted to w_restart
              if (w_hi || w_lo) begin
                r_state  <= SETTLE;
                r_ftw    <= w_hi ? r_ftw - 1'b1 : r_ftw + 1'b1;
                r_run    <= '0;
                r_locked <= 1'b0;
              end else begin
                r_state <= MEASURE;
                r_run   <= w_run_next;
                if (w_run_next >= RUN_W'(LOCK_WINDOWS)) r_locked <= 1'b1;
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  dco_edge_counter #(
    .CNT_W   (CNT_W),
    .WIN_CYC (WIN_CYC)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .start_window (w_start_win),
    .abort        (start),
    .dco_clk_in   (dco_clk_in),
    .meas_cnt     (w_meas_cnt),
    .meas_valid   (w_meas_valid)
  );

  assign CTW        = r_ctw;
  assign FTW        = r_ftw;
  assign enable     = r_en;
  assign busy       = r_busy;
  assign locked     = r_locked;
  assign meas_cnt   = w_meas_cnt;
  assign meas_valid = w_meas_valid;

endmodule

// File: tb/tb_dco_freq_lock.sv
// Directed bench for dco_freq_lock.
// Main DUT uses a 512-cycle window so the model can deliver up to 256 distinct
// edges per window (count = 4*CTW + FTW/4, capped at 256). A second instance
// with default parameters checks the raw counter against a period-8 input.
module tb_dco_freq_lock;

  localparam int unsigned WIN = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] target;
  logic        dco;
  logic [7:0]  ctw, ftw;
  logic        enable, busy, locked, mv;
  logic [15:0] mcnt;

  logic        start2;
  logic [15:0] target2;
  logic        dco2;
  logic [7:0]  ctw2, ftw2;
  logic        enable2, busy2, locked2, mv2;
  logic [15:0] mcnt2;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned acc      = 0;
  int unsigned model_n  = 0;
  int unsigned ph2      = 0;

  always #5 clk = ~clk;

  dco_freq_lock #(.WIN_CYC(WIN)) u_dut (
    .clk(clk), .rst(rst), .start(start), .target_cnt(target), .dco_clk_in(dco),
    .CTW(ctw), .FTW(ftw), .enable(enable), .busy(busy), .locked(locked),
    .meas_cnt(mcnt), .meas_valid(mv)
  );

  dco_freq_lock u_dut256 (
    .clk(clk), .rst(rst), .start(start2), .target_cnt(target2), .dco_clk_in(dco2),
    .CTW(ctw2), .FTW(ftw2), .enable(enable2), .busy(busy2), .locked(locked2),
    .meas_cnt(mcnt2), .meas_valid(mv2)
  );

  // DCO model: phase accumulator, one-cycle-high pulse per wrap
  always @(negedge clk) begin
    model_n = 4 * int'(ctw) + int'(ftw) / 4;
    if (model_n > 256) model_n = 256;
    if (!enable) begin
      acc = 0;
      dco = 1'b0;
    end else begin
      acc = acc + model_n;
      if (acc >= WIN) begin
        acc = acc - WIN;
        dco = 1'b1;
      end else begin
        dco = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    ph2  = (ph2 + 1) % 8;
    dco2 = (ph2 >= 4);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // waits for meas_valid, then returns right after the following DECIDE edge
  task automatic window(input string tag);
    int unsigned k = 0;
    while (mv !== 1'b1 && k < 1200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_in_time"}, 32'(k < 1200), 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctw"}, 32'(ctw), 32'h80);
    check({tag, "_ftw"}, 32'(ftw), 32'h80);
    check({tag, "_en"},  32'(enable), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_lock"}, 32'(locked), 32'd0);
    check({tag, "_mv"},  32'(mv), 32'd0);
    check({tag, "_mcnt"}, 32'(mcnt), 32'd0);
  endtask

  logic [7:0] coarse_exp [8] = '{8'h40, 8'h20, 8'h30, 8'h38, 8'h34, 8'h32, 8'h33, 8'h32};
  logic [7:0] fine_exp   [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h03, 8'h03};
  logic [7:0] track_exp  [5] = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd8};

  initial begin
    int unsigned k;
    int unsigned pulses;
    logic        saw_lock;

    rst = 1'b1; start = 1'b0; start2 = 1'b0; target = '0; target2 = 16'd32;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // counter on a fixed period-8 input, 256-cycle window
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("cnt_en", 32'(enable2), 32'd1);
    check("cnt_ctw_trial", 32'(ctw2), 32'h80);
    k = 0;
    while (mv2 !== 1'b1 && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("cnt_mv_seen", 32'(k < 600), 32'd1);
    check("cnt_32pm1", 32'(mcnt2 >= 16'd31 && mcnt2 <= 16'd33), 32'd1);
    @(negedge clk);
    check("cnt_mv_pulse", 32'(mv2), 32'd0);

    // acquisition to target 200
    target = 16'd200;
    pulse_start();
    check("acq_ctw0", 32'(ctw), 32'h80);
    check("acq_ftw0", 32'(ftw), 32'h00);
    check("acq_en", 32'(enable), 32'd1);
    check("acq_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      window("coarse");
      check("coarse_ctw", 32'(ctw), 32'(coarse_exp[i]));
    end
    check("coarse_ftw_trial", 32'(ftw), 32'h80);
    for (int i = 0; i < 8; i++) begin
      window("fine");
      check("fine_ftw", 32'(ftw), 32'(fine_exp[i]));
      check("fine_lock", 32'(locked), 32'd0);
    end
    check("acq_ctw50", 32'(ctw), 32'd50);
    for (int i = 0; i < 4; i++) begin
      window("lock");
      check("lock_flag", 32'(locked), 32'(i == 3));
      check("lock_ftw", 32'(ftw), 32'd3);
    end
    check("lock_mcnt", 32'(mcnt), 32'd200);

    // tracking to target 203
    target = 16'd203;
    for (int i = 0; i < 5; i++) begin
      window("track");
      check("track_ftw", 32'(ftw), 32'(track_exp[i]));
      check("track_unlock", 32'(locked), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      window("relock");
      check("relock_flag", 32'(locked), 32'(i == 3));
      check("relock_ftw", 32'(ftw), 32'd8);
    end
    check("relock_mcnt", 32'(mcnt), 32'd202);

    // rail: unreachable target
    target = 16'd2000;
    pulse_start();
    saw_lock = 1'b0;
    for (int i = 0; i < 16; i++) begin
      window("rail");
      saw_lock = saw_lock | locked;
      if (i == 7)  check("rail_ctw_ff", 32'(ctw), 32'hFF);
      if (i == 15) check("rail_ftw_ff", 32'(ftw), 32'hFF);
    end
    window("rail_hit");
    saw_lock = saw_lock | locked;
    check("rail_ctw_restart", 32'(ctw), 32'h80);
    check("rail_ftw_restart", 32'(ftw), 32'h00);
    check("rail_busy", 32'(busy), 32'd1);
    window("rail_again");
    saw_lock = saw_lock | locked;
    check("rail_ctw_c0", 32'(ctw), 32'hC0);
    check("rail_never_lock", 32'(saw_lock), 32'd0);

    // abort with rst mid-FINE
    target = 16'd200;
    pulse_start();
    for (int i = 0; i < 11; i++) window("abort_pre");
    check("abort_mid_fine_ftw", 32'(ftw), 32'h10);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("abort");
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (mv === 1'b1) pulses++;
    end
    check("abort_no_mv", pulses, 32'd0);
    pulse_start();
    for (int i = 0; i < 16; i++) window("reacq");
    check("reacq_ctw", 32'(ctw), 32'd50);
    check("reacq_ftw", 32'(ftw), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
